// File: rtl/bound_led_monitor.sv
// bound_led_monitor: decodes a thermometer-coded LED bar into level and direction, flags turning points and bus errors.
// Define BOUND_LED_MONITOR_STALL_CHECK_EN to add the STALL_MAX parameter, the err_stall output and its hold counter.
module bound_led_monitor #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LVL_W  = 5,
  parameter int unsigned TURN_W = 8
`ifdef BOUND_LED_MONITOR_STALL_CHECK_EN
  ,
  parameter int unsigned STALL_MAX = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  led,
  input  logic              clr_stats,
  output logic [LVL_W-1:0]  level,
  output logic [1:0]        dir,
  output logic              turn,
  output logic [LVL_W-1:0]  turn_level,
  output logic [TURN_W-1:0] turn_cnt,
  output logic              err_code,
  output logic              err_step,
`ifdef BOUND_LED_MONITOR_STALL_CHECK_EN
  output logic              err_stall,
`endif
  output logic              err_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10,
    ST_HOLD = 2'b11
  } dir_e;

  localparam int unsigned DIFF_W = LVL_W + 1;
  localparam logic signed [DIFF_W-1:0] ONE_S = DIFF_W'(1);

  dir_e              dir_q, dir_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              last_dn_q, last_dn_d;
  logic              turn_q, turn_d;
  logic [LVL_W-1:0]  turn_level_q, turn_level_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  logic              err_code_q, err_code_d;
  logic              err_step_q, err_step_d;
  logic              err_sticky_q, err_sticky_d;
  logic              stall_err_c;

  logic [WIDTH-1:0]        led_inc_c;
  logic                    legal_c;
  logic [LVL_W-1:0]        n_c;
  logic signed [DIFF_W-1:0] diff_c;
  logic signed [DIFF_W-1:0] abs_c;
  logic                    up_c;
  logic                    down_c;
  logic                    step_big_c;

  // A thermometer code has no set bit above the carry chain of led+1.
  always_comb begin
    led_inc_c = led + WIDTH'(1);
    legal_c   = ((led & led_inc_c) == '0);
    n_c       = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      n_c = n_c + LVL_W'(led[i]);
    end
    diff_c     = $signed({1'b0, n_c}) - $signed({1'b0, level_q});
    up_c       = (diff_c > $signed(DIFF_W'(0)));
    down_c     = (diff_c < $signed(DIFF_W'(0)));
    abs_c      = down_c ? -diff_c : diff_c;
    step_big_c = (abs_c > ONE_S);
  end

  // Direction FSM, turn detection and statistics.
  always_comb begin
    dir_d        = dir_q;
    level_d      = level_q;
    last_dn_d    = last_dn_q;
    turn_d       = 1'b0;
    turn_level_d = turn_level_q;
    turn_cnt_d   = turn_cnt_q;
    err_code_d   = 1'b0;
    err_step_d   = 1'b0;
    err_sticky_d = err_sticky_q;

    if (en) begin
      if (!legal_c) begin
        err_code_d = 1'b1;
      end else begin
        err_step_d = step_big_c;
        level_d    = n_c;
        case (dir_q)
          ST_IDLE: begin
            if (up_c) dir_d = ST_UP;
          end
          ST_UP: begin
            if (down_c) begin
              dir_d  = ST_DOWN;
              turn_d = 1'b1;
            end else if (!up_c) begin
              dir_d = ST_HOLD;
            end
          end
          ST_DOWN: begin
            if (up_c) begin
              dir_d  = ST_UP;
              turn_d = 1'b1;
            end else if (!down_c) begin
              dir_d = (n_c == '0) ? ST_IDLE : ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (up_c) begin
              dir_d  = ST_UP;
              turn_d = last_dn_q;
            end else if (down_c) begin
              dir_d  = ST_DOWN;
              turn_d = !last_dn_q;
            end
          end
          default: dir_d = ST_IDLE;
        endcase
        if (up_c) begin
          last_dn_d = 1'b0;
        end else if (down_c) begin
          last_dn_d = 1'b1;
        end
        if (turn_d) turn_level_d = level_q;
      end
    end

    if (clr_stats) begin
      turn_cnt_d = '0;
    end else if (turn_d && (turn_cnt_q != '1)) begin
      turn_cnt_d = turn_cnt_q + TURN_W'(1);
    end
    err_sticky_d = (err_sticky_q & ~clr_stats) | err_code_d | err_step_d | stall_err_c;
  end

`ifdef BOUND_LED_MONITOR_STALL_CHECK_EN
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               err_stall_q;

  // Hold counter: saturates at STALL_MAX and pulses once on arrival.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall_err_c = 1'b0;
    if (en && legal_c) begin
      if ((level_d != level_q) || (dir_d == ST_IDLE)) begin
        stall_cnt_d = '0;
      end else if ((dir_d == ST_HOLD) && (level_d != '0) &&
                   (stall_cnt_q != STALL_W'(STALL_MAX))) begin
        stall_cnt_d = stall_cnt_q + STALL_W'(1);
        stall_err_c = (stall_cnt_d == STALL_W'(STALL_MAX));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      err_stall_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_stall_q <= stall_err_c;
    end
  end

  assign err_stall = err_stall_q;
`else
  assign stall_err_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q        <= ST_IDLE;
      level_q      <= '0;
      last_dn_q    <= 1'b0;
      turn_q       <= 1'b0;
      turn_level_q <= '0;
      turn_cnt_q   <= '0;
      err_code_q   <= 1'b0;
      err_step_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      level_q      <= level_d;
      last_dn_q    <= last_dn_d;
      turn_q       <= turn_d;
      turn_level_q <= turn_level_d;
      turn_cnt_q   <= turn_cnt_d;
      err_code_q   <= err_code_d;
      err_step_q   <= err_step_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign level      = level_q;
  assign dir        = dir_q;
  assign turn       = turn_q;
  assign turn_level = turn_level_q;
  assign turn_cnt   = turn_cnt_q;
  assign err_code   = err_code_q;
  assign err_step   = err_step_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_bound_led_monitor.sv
// tb_bound_led_monitor: directed and randomized stimulus for bound_led_monitor, checked every cycle
// against a rule-level model of level, direction, turns and error flags.
module tb_bound_led_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] led;
  logic        clr_stats;
  logic [4:0]  level;
  logic [1:0]  dir;
  logic        turn;
  logic [4:0]  turn_level;
  logic [7:0]  turn_cnt;
  logic        err_code;
  logic        err_step;
  logic        err_sticky;
`ifdef BOUND_LED_MONITOR_STALL_CHECK_EN
  logic        err_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  bound_led_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .led        (led),
    .clr_stats  (clr_stats),
    .level      (level),
    .dir        (dir),
    .turn       (turn),
    .turn_level (turn_level),
    .turn_cnt   (turn_cnt),
    .err_code   (err_code),
    .err_step   (err_step),
`ifdef BOUND_LED_MONITOR_STALL_CHECK_EN
    .err_stall  (err_stall),
`endif
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // Expected architectural state: dir uses the port codes 0 idle, 1 up, 2 down, 3 hold.
  typedef struct {
    int level;
    int dir;
    int last;
    int tl;
    int cnt;
    bit turn;
    bit ec;
    bit es;
    bit sticky;
  } mstate_t;

  mstate_t m;

  function automatic logic [15:0] thermo(input int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  function automatic int decode(input logic [15:0] v);
    for (int k = 0; k <= 16; k++) begin
      if (v == thermo(k)) return k;
    end
    return -1;
  endfunction

  function automatic mstate_t mreset();
    mstate_t t;
    t.level = 0; t.dir = 0; t.last = 1; t.tl = 0; t.cnt = 0;
    t.turn = 0; t.ec = 0; t.es = 0; t.sticky = 0;
    return t;
  endfunction

  // A turn is any movement against the last movement, unless starting out of idle.
  function automatic mstate_t model_step(input mstate_t s, input logic e, input logic c,
                                         input logic [15:0] v);
    mstate_t t;
    int n, delta, sgn;
    t = s;
    t.turn = 0; t.ec = 0; t.es = 0;
    if (e) begin
      n = decode(v);
      if (n < 0) begin
        t.ec = 1;
      end else begin
        delta = n - s.level;
        sgn   = (delta > 0) ? 1 : ((delta < 0) ? -1 : 0);
        if (delta > 1 || delta < -1) t.es = 1;
        if (sgn != 0 && s.dir != 0 && sgn != s.last) begin
          t.turn = 1;
          t.tl   = s.level;
        end
        if (sgn > 0) t.dir = 1;
        else if (sgn < 0) t.dir = 2;
        else if (s.dir == 0 || (s.dir == 2 && n == 0)) t.dir = 0;
        else t.dir = 3;
        if (sgn != 0) t.last = sgn;
        t.level = n;
      end
    end
    if (c) t.cnt = 0;
    else if (t.turn && t.cnt < 255) t.cnt = t.cnt + 1;
    t.sticky = (s.sticky && !c) || t.ec || t.es;
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mreset();
    else     m <= model_step(m, en, clr_stats, led);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("level",      32'(level),      32'(m.level));
      chk("dir",        32'(dir),        32'(m.dir));
      chk("turn",       32'(turn),       32'(m.turn));
      chk("turn_level", 32'(turn_level), 32'(m.tl));
      chk("turn_cnt",   32'(turn_cnt),   32'(m.cnt));
      chk("err_code",   32'(err_code),   32'(m.ec));
      chk("err_step",   32'(err_step),   32'(m.es));
      chk("err_sticky", 32'(err_sticky), 32'(m.sticky));
    end
  end

  task automatic drive(input logic [15:0] v, input logic e = 1'b1, input logic c = 1'b0);
    led       = v;
    en        = e;
    clr_stats = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  int lv;
  int wdir;
  logic [15:0] rv;

  initial begin
    rst = 1'b1; en = 1'b0; led = '0; clr_stats = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_turn_cnt", 32'(turn_cnt), 32'd0);
    chk_on = 1'b1;
    rst = 1'b0;

    repeat (5) drive(16'h0000);
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_dir", 32'(dir), 32'd0);

    for (int k = 1; k <= 16; k++) drive(thermo(k));
    chk("ramp_top_dir", 32'(dir), 32'd1);
    drive(thermo(15));
    chk("bound_hi_turn", 32'(turn), 32'd1);
    chk("bound_hi_level", 32'(turn_level), 32'd16);
    chk("down_dir", 32'(dir), 32'd2);
    for (int k = 14; k >= 5; k--) drive(thermo(k));
    drive(thermo(6));
    chk("bound_lo_turn", 32'(turn), 32'd1);
    chk("bound_lo_level", 32'(turn_level), 32'd5);
    chk("ramp_turn_cnt", 32'(turn_cnt), 32'd2);
    chk("ramp_sticky", 32'(err_sticky), 32'd0);

    drive(thermo(5)); drive(thermo(4)); drive(thermo(3));
    drive(16'h0005);
    chk("illegal_err_code", 32'(err_code), 32'd1);
    chk("illegal_level", 32'(level), 32'd3);
    chk("illegal_sticky", 32'(err_sticky), 32'd1);
    drive(thermo(4));
    chk("err_code_once", 32'(err_code), 32'd0);
    drive(16'h00FF);
    chk("step_err", 32'(err_step), 32'd1);
    chk("step_level", 32'(level), 32'd8);
    chk("step_dir", 32'(dir), 32'd1);

    drive(thermo(6)); drive(thermo(7)); drive(thermo(7)); drive(thermo(7));
    chk("hold_dir", 32'(dir), 32'd3);
    drive(thermo(6));
    chk("hold_rev_turn", 32'(turn), 32'd1);
    chk("hold_rev_level", 32'(turn_level), 32'd7);
    chk("hold_rev_dir", 32'(dir), 32'd2);
    drive(thermo(6), 1'b1, 1'b1);
    chk("clr_turn_cnt", 32'(turn_cnt), 32'd0);
    chk("clr_sticky", 32'(err_sticky), 32'd0);

    drive(thermo(7)); drive(thermo(8)); drive(thermo(9));
    chk("pre_rst_level", 32'(level), 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_dir", 32'(dir), 32'd0);
    chk("mid_rst_turn_cnt", 32'(turn_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(16'h0007);
    chk("post_rst_step", 32'(err_step), 32'd1);
    chk("post_rst_level", 32'(level), 32'd3);
    chk("post_rst_dir", 32'(dir), 32'd1);

    drive(16'h0005, 1'b0, 1'b0);
    chk("en_low_no_err", 32'(err_code), 32'd0);
    chk("en_low_level", 32'(level), 32'd3);
    drive(16'h0005, 1'b1, 1'b1);
    chk("clr_with_err_sticky", 32'(err_sticky), 32'd1);
    chk("clr_with_err_cnt", 32'(turn_cnt), 32'd0);

    drive(thermo(4));
    for (int k = 0; k < 140; k++) begin
      drive(thermo(5));
      drive(thermo(4));
    end
    chk("turn_cnt_sat", 32'(turn_cnt), 32'd255);

    lv = 4; wdir = 1;
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lv = 0;
      end else begin
        case ($urandom_range(0, 99)) inside
          [0:4]: begin
            rv = 16'($urandom);
            if (decode(rv) >= 0) rv = 16'h0A00;
          end
          [5:11]: begin
            lv = $urandom_range(0, 16);
            rv = thermo(lv);
          end
          default: begin
            if ($urandom_range(0, 7) == 0) wdir = -wdir;
            if ($urandom_range(0, 5) != 0) lv = lv + wdir;
            if (lv > 16) begin lv = 16; wdir = -1; end
            if (lv < 0)  begin lv = 0;  wdir = 1;  end
            rv = thermo(lv);
          end
        endcase
        drive(rv, ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0));
      end
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bound_led_monitor.md
Name: bound_led_monitor

Overview:
- Receive-side observer for the bound-flasher LED bar. Samples the thermometer-coded `led` bus every enabled cycle and decodes it into a lamp level and a direction of travel.
- Detects turning points (kick-back/bound points) and flags malformed or illegal bus activity.
- Sits beside the flasher in the system and in benches, as the reader for the flasher's `led` writer. Its outputs feed the scoreboard and status registers.

Parameters:
- WIDTH, 16, number of lamps on the `led` bus.
- LVL_W, 5, width of the decoded level; must satisfy 2^LVL_W > WIDTH.
- TURN_W, 8, width of the turning-point counter.
- STALL_MAX, 64, hold-cycle limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  sample enable; when low, all state holds and pulses stay 0.
- led  in  WIDTH  observed lamp bus; bit 0 is the first lamp.
- clr_stats  in  1  synchronous clear of `turn_cnt` and `err_sticky`.
- level  out  LVL_W  number of lit lamps, 0..WIDTH.
- dir  out  2  travel direction: 00 IDLE, 01 UP, 10 DOWN, 11 HOLD.
- turn  out  1  one-cycle pulse when the direction reverses.
- turn_level  out  LVL_W  level at the most recent turning point.
- turn_cnt  out  TURN_W  saturating count of turning points.
- err_code  out  1  one-cycle pulse: sample was not a thermometer code.
- err_step  out  1  one-cycle pulse: level changed by more than 1.
- err_sticky  out  1  OR of all error pulses since reset or `clr_stats`.

Behaviour:
- Reset values (asynchronous, active-high `rst`): all outputs 0; FSM in IDLE; previous-level register 0.
- Latency: all outputs are registered. A sample taken at edge N is reflected at edge N+1.
- Legal sample: `led` == (1<<n)-1 for some n in 0..WIDTH; n is the new level. All zeros gives n=0; all ones gives n=WIDTH.
- Illegal sample:
  - `err_code` pulses.
  - `level`, `dir` and the FSM hold their previous values.
  - `err_step` is not evaluated for that sample.
- Step check, legal samples only: if |n - level| > 1, `err_step` pulses. The new level is still accepted and the direction is taken from the sign of the change.
- Direction FSM (legal samples only):
  - IDLE: n>0 -> UP. n==0 -> stay IDLE.
  - UP: n>level -> UP. n<level -> DOWN with turn. n==level -> HOLD.
  - DOWN: n<level -> DOWN. n>level -> UP with turn. n==level: if n==0 go to IDLE, else HOLD.
  - HOLD: n>level -> UP. n<level -> DOWN. n==level -> HOLD.
  - In HOLD, a turn fires only if the new direction is opposite to the last non-HOLD direction. The monitor keeps a 1-bit last-direction register for this.
- DOWN reaching 0 is not a turn. IDLE -> UP is not a turn.
- On a turn:
  - `turn` pulses.
  - `turn_level` = level before the reversing sample, i.e. the extremum.
  - `turn_cnt` increments and saturates at all-ones.
- `clr_stats`:
  - Takes priority over a same-cycle increment; `turn_cnt` becomes 0.
  - `err_sticky` becomes 0 unless an error pulse fires in the same cycle, in which case it becomes 1.
- `en` low: sample ignored; no pulses; `clr_stats` is still honoured.
- `rst` mid-sequence: immediate return to reset values. The first legal sample afterwards is judged against level 0, so a jump to a level >1 gives `err_step`.
- Arithmetic: level difference computed at LVL_W+1 bits, signed; no wrap.

Optional Feature:
- Macro: BOUND_LED_MONITOR_STALL_CHECK_EN.
- Defined:
  - Adds output `err_stall` (1 bit) and a hold counter of width ceil(log2(STALL_MAX+1)).
  - The counter increments each enabled legal cycle where dir==HOLD and level>0. It clears on any level change, on IDLE and on reset.
  - When the counter reaches STALL_MAX, `err_stall` pulses once, `err_sticky` sets, and the counter stops at STALL_MAX until cleared.
- Undefined: the port is absent, no counter is built, and behaviour is identical to the above.

Test Plan:
- Reset then IDLE: `rst`=1 for 2 cycles, then `led`=0 for 5 cycles -> `level`=0, `dir`=00, no pulses, `turn_cnt`=0.
- Ramp and bound: levels 0->1->...->16->15->...->5->6 -> `dir` UP then DOWN then UP.
  - `turn` at 16->15 with `turn_level`=16.
  - `turn` at 5->6 with `turn_level`=5.
  - `turn_cnt`=2; no errors.
- Illegal code: `led`=16'h0005 while at level 3 -> `err_code`=1 for one cycle, `level` stays 3, `err_sticky`=1.
- Step error: level 4 then `led`=16'h00FF -> `err_step`=1, `level`=8, `dir`=UP.
- Hold then reverse: 6,7,7,7,6 -> HOLD for 2 cycles, then DOWN with `turn`, `turn_level`=7.
  - Then `clr_stats` together with a non-error sample -> `turn_cnt`=0, `err_sticky`=0.
- Reset mid-ramp at level 9, then `led`=16'h0007 -> outputs 0 during reset; afterwards `err_step`=1, `level`=3, `dir`=UP.
  - With the macro defined: hold at level 4 for 64 cycles -> a single `err_stall` pulse.
